// File: rtl/uart_cmd_pkg.sv
// Shared definitions for the UART command parser: ASCII constants, parser
// state encoding and byte classification helpers.
package uart_cmd_pkg;

  localparam int unsigned BYTE_W = 8;

  localparam logic [BYTE_W-1:0] CHAR_START = 8'h2A;  // '*'
  localparam logic [BYTE_W-1:0] CHAR_CR    = 8'h0D;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CMD   = 2'd1,
    ARG   = 2'd2,
    FLUSH = 2'd3
  } parse_state_t;

  // '0'-'9', 'A'-'F', 'a'-'f'
  function automatic logic is_hex(input logic [BYTE_W-1:0] b);
    return ((b >= 8'h30) && (b <= 8'h39)) ||
           ((b >= 8'h41) && (b <= 8'h46)) ||
           ((b >= 8'h61) && (b <= 8'h66));
  endfunction

  // Only meaningful when is_hex(b) is true.
  function automatic logic [3:0] hex_to_nib(input logic [BYTE_W-1:0] b);
    logic [BYTE_W-1:0] v;
    if (b <= 8'h39)      v = b - 8'h30;
    else if (b <= 8'h46) v = b - 8'h37;
    else                 v = b - 8'h57;
    return 4'(v);
  endfunction

  // 'A'-'Z', 'a'-'z'
  function automatic logic is_letter(input logic [BYTE_W-1:0] b);
    return ((b >= 8'h41) && (b <= 8'h5A)) ||
           ((b >= 8'h61) && (b <= 8'h7A));
  endfunction

  function automatic logic [BYTE_W-1:0] to_upper(input logic [BYTE_W-1:0] b);
    if ((b >= 8'h61) && (b <= 8'h7A)) return BYTE_W'(b - 8'h20);
    return b;
  endfunction

endpackage

// File: rtl/uart_cmd_parse.sv
// ASCII command decoder downstream of uart_rx: '*' + letter + 0..MAX_DIGITS
// hex digits + CR. Emits a cmd_valid strobe with code/argument, or a cmd_err
// strobe on malformed input, framing error or inter-character timeout.
//
// Ports:
//   clk_rx, rst_clk_rx      receive clock, synchronous active-high reset
//   rx_data, rx_data_rdy    received byte and its one-cycle strobe
//   frm_err                 framing error qualifier for the current byte
//   cmd_valid, cmd_err      one-cycle result strobes (never together)
//   cmd_code, cmd_arg,      last decoded command, held between cmd_valid
//   cmd_arg_cnt
//   busy                    parser is inside a command (state != IDLE)
module uart_cmd_parse
  import uart_cmd_pkg::*;
#(
  parameter  int unsigned MAX_DIGITS     = 4,
  parameter  int unsigned TIMEOUT_CYCLES = 125_000_000,
  localparam int unsigned ARG_WIDTH      = 4 * MAX_DIGITS
) (
  input  logic                 clk_rx,
  input  logic                 rst_clk_rx,
  input  logic [7:0]           rx_data,
  input  logic                 rx_data_rdy,
  input  logic                 frm_err,
  output logic                 cmd_valid,
  output logic [7:0]           cmd_code,
  output logic [ARG_WIDTH-1:0] cmd_arg,
  output logic [3:0]           cmd_arg_cnt,
  output logic                 cmd_err,
  output logic                 busy
);

  localparam int unsigned TO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int unsigned CNT_W = 4;

  parse_state_t           state, state_nxt;
  logic [7:0]             code_acc, code_nxt;
  logic [ARG_WIDTH-1:0]   arg_acc, arg_nxt;
  logic [CNT_W-1:0]       cnt_acc, cnt_nxt;
  logic [TO_W-1:0]        to_cnt, to_nxt;
  logic                   valid_nxt, err_nxt;
  logic                   to_expired;

  // Timeout fires only on a silent cycle; a byte arriving in the expiry cycle wins.
  assign to_expired = (TIMEOUT_CYCLES != 0) && (state != IDLE) && !rx_data_rdy &&
                      (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  // State register
  always_ff @(posedge clk_rx) begin
    if (rst_clk_rx) state <= IDLE;
    else            state <= state_nxt;
  end

  // Next-state, accumulator and strobe decode
  always_comb begin
    state_nxt = state;
    code_nxt  = code_acc;
    arg_nxt   = arg_acc;
    cnt_nxt   = cnt_acc;
    valid_nxt = 1'b0;
    err_nxt   = 1'b0;
    to_nxt    = ((state == IDLE) || rx_data_rdy) ? '0 : to_cnt + TO_W'(1);

    if (rx_data_rdy) begin
      unique case (state)
        IDLE: begin
          // Corrupted bytes cannot open a command.
          if (!frm_err && (rx_data == CHAR_START)) state_nxt = CMD;
        end
        CMD: begin
          if (frm_err) begin
            err_nxt   = 1'b1;
            state_nxt = FLUSH;
          end else if (rx_data == CHAR_START) begin
            state_nxt = CMD;
          end else if (is_letter(rx_data)) begin
            code_nxt  = to_upper(rx_data);
            arg_nxt   = '0;
            cnt_nxt   = '0;
            state_nxt = ARG;
          end else begin
            err_nxt   = 1'b1;
            state_nxt = FLUSH;
          end
        end
        ARG: begin
          if (frm_err) begin
            err_nxt   = 1'b1;
            state_nxt = FLUSH;
          end else if (is_hex(rx_data)) begin
            if (cnt_acc < CNT_W'(MAX_DIGITS)) begin
              // Truncating cast drops the top nibble; works for MAX_DIGITS=1 too.
              arg_nxt = ARG_WIDTH'({arg_acc, hex_to_nib(rx_data)});
              cnt_nxt = cnt_acc + CNT_W'(1);
            end else begin
              err_nxt   = 1'b1;
              state_nxt = FLUSH;
            end
          end else if (rx_data == CHAR_CR) begin
            valid_nxt = 1'b1;
            state_nxt = IDLE;
          end else if (rx_data == CHAR_START) begin
            err_nxt   = 1'b1;
            state_nxt = CMD;
          end else begin
            err_nxt   = 1'b1;
            state_nxt = FLUSH;
          end
        end
        FLUSH: begin
          if (!frm_err) begin
            if (rx_data == CHAR_CR)         state_nxt = IDLE;
            else if (rx_data == CHAR_START) state_nxt = CMD;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end else if (to_expired) begin
      err_nxt   = (state != FLUSH);
      state_nxt = IDLE;
      to_nxt    = '0;
    end
  end

  // Accumulators, timeout counter and registered outputs
  always_ff @(posedge clk_rx) begin
    if (rst_clk_rx) begin
      code_acc    <= '0;
      arg_acc     <= '0;
      cnt_acc     <= '0;
      to_cnt      <= '0;
      cmd_valid   <= 1'b0;
      cmd_err     <= 1'b0;
      cmd_code    <= '0;
      cmd_arg     <= '0;
      cmd_arg_cnt <= '0;
      busy        <= 1'b0;
    end else begin
      code_acc  <= code_nxt;
      arg_acc   <= arg_nxt;
      cnt_acc   <= cnt_nxt;
      to_cnt    <= to_nxt;
      cmd_valid <= valid_nxt;
      cmd_err   <= err_nxt;
      busy      <= (state_nxt != IDLE);
      // Published fields move only with a completed command.
      if (valid_nxt) begin
        cmd_code    <= code_acc;
        cmd_arg     <= arg_acc;
        cmd_arg_cnt <= cnt_acc;
      end
    end
  end

endmodule

// File: tb/tb_uart_cmd_parse.sv
// Self-checking bench for uart_cmd_parse: a byte-level reference model
// predicts every output each cycle; directed sequences add literal checks.
module tb_uart_cmd_parse;

  localparam int MD = 4;
  localparam int TO = 100;
  localparam int AW = 4 * MD;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [7:0]    rx_data = 8'h00;
  logic          rx_data_rdy = 1'b0;
  logic          frm_err = 1'b0;
  logic          cmd_valid, cmd_err, busy;
  logic [7:0]    cmd_code;
  logic [AW-1:0] cmd_arg;
  logic [3:0]    cmd_arg_cnt;

  uart_cmd_parse #(.MAX_DIGITS(MD), .TIMEOUT_CYCLES(TO)) dut (
    .clk_rx      (clk),
    .rst_clk_rx  (rst),
    .rx_data     (rx_data),
    .rx_data_rdy (rx_data_rdy),
    .frm_err     (frm_err),
    .cmd_valid   (cmd_valid),
    .cmd_code    (cmd_code),
    .cmd_arg     (cmd_arg),
    .cmd_arg_cnt (cmd_arg_cnt),
    .cmd_err     (cmd_err),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int n_valid  = 0;
  int n_err    = 0;
  bit cmp_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // mode: 0 waiting for '*', 1 want letter, 2 collecting digits, 3 discarding
  int         mode = 0;
  int         quiet = 0;
  logic [7:0] letter = 8'h00;
  int         digits[$];
  logic       e_valid = 1'b0, e_err = 1'b0, e_busy = 1'b0;
  logic [7:0] e_code = 8'h00;
  logic [31:0] e_arg = 0;
  logic [3:0] e_cnt = 4'h0;

  function automatic bit m_hex(input logic [7:0] c);
    return (c inside {["0":"9"], ["A":"F"], ["a":"f"]});
  endfunction
  function automatic int m_val(input logic [7:0] c);
    if (c <= "9") return int'(c) - int'("0");
    return int'(c | 8'h20) - int'("a") + 10;
  endfunction

  always @(posedge clk) begin
    e_valid = 1'b0;
    e_err   = 1'b0;
    if (rst) begin
      mode = 0; quiet = 0; digits.delete();
      e_code = 8'h00; e_arg = 0; e_cnt = 4'h0;
    end else if (rx_data_rdy) begin
      quiet = 0;
      case (mode)
        0: if (!frm_err && rx_data == "*") mode = 1;
        1: begin
          if (frm_err) begin e_err = 1; mode = 3; end
          else if (rx_data == "*") mode = 1;
          else if (rx_data inside {["A":"Z"], ["a":"z"]}) begin
            letter = rx_data & 8'hDF; digits.delete(); mode = 2;
          end else begin e_err = 1; mode = 3; end
        end
        2: begin
          if (frm_err) begin e_err = 1; mode = 3; end
          else if (m_hex(rx_data)) begin
            if (digits.size() < MD) digits.push_back(m_val(rx_data));
            else begin e_err = 1; mode = 3; end
          end else if (rx_data == 8'h0D) begin
            int v;
            v = 0;
            foreach (digits[i]) v = v * 16 + digits[i];
            e_valid = 1; e_code = letter; e_arg = v; e_cnt = 4'(digits.size());
            mode = 0;
          end else if (rx_data == "*") begin e_err = 1; mode = 1; end
          else begin e_err = 1; mode = 3; end
        end
        default: if (!frm_err) begin
          if (rx_data == 8'h0D) mode = 0;
          else if (rx_data == "*") mode = 1;
        end
      endcase
    end else if (mode != 0) begin
      quiet++;
      if (quiet == TO) begin
        e_err = (mode != 3);
        mode  = 0;
      end
    end
    e_busy = (mode != 0);
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (cmp_en) begin
      check("cmd_valid", 32'(cmd_valid), 32'(e_valid));
      check("cmd_err", 32'(cmd_err), 32'(e_err));
      check("cmd_code", 32'(cmd_code), 32'(e_code));
      check("cmd_arg", 32'(cmd_arg), e_arg);
      check("cmd_arg_cnt", 32'(cmd_arg_cnt), 32'(e_cnt));
      check("busy", 32'(busy), 32'(e_busy));
      if (cmd_valid === 1'b1) n_valid++;
      if (cmd_err === 1'b1) n_err++;
    end
  end

  // ---------------- stimulus ----------------
  // Ends #1 after the negedge following the byte's posedge, so strobes caused
  // by this byte are visible and already tallied.
  task automatic send_byte(input logic [7:0] b, input logic fe = 1'b0);
    @(negedge clk);
    rx_data = b; rx_data_rdy = 1'b1; frm_err = fe;
    @(negedge clk);
    rx_data_rdy = 1'b0; frm_err = 1'b0;
    #1;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) begin
      send_byte(s.getc(i));
      repeat (2) @(negedge clk);
    end
  endtask

  int v0, e0;

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    cmp_en = 1'b1;
    #1;
    check("reset_outputs", {cmd_valid, cmd_err, busy, cmd_code, cmd_arg, cmd_arg_cnt}, 32'h0);

    // "*L3C<CR>"
    v0 = n_valid; e0 = n_err;
    send_str("*L3C");
    send_byte(8'h0D);
    check("L_valid_at_cr", 32'(cmd_valid), 32'h1);
    check("L_code", 32'(cmd_code), 32'h4C);
    check("L_arg", 32'(cmd_arg), 32'h003C);
    check("L_cnt", 32'(cmd_arg_cnt), 32'h2);
    repeat (3) @(negedge clk); #1;
    check("L_valid_count", 32'(n_valid - v0), 32'h1);
    check("L_err_count", 32'(n_err - e0), 32'h0);

    // "*w<CR>" then "xx*Babcd<CR>"
    send_str("*w");
    send_byte(8'h0D);
    check("w_code", 32'(cmd_code), 32'h57);
    check("w_arg", 32'(cmd_arg), 32'h0);
    check("w_cnt", 32'(cmd_arg_cnt), 32'h0);
    e0 = n_err;
    send_str("xx*Babcd");
    send_byte(8'h0D);
    check("B_valid", 32'(cmd_valid), 32'h1);
    check("B_code", 32'(cmd_code), 32'h42);
    check("B_arg", 32'(cmd_arg), 32'hABCD);
    check("B_cnt", 32'(cmd_arg_cnt), 32'h4);
    check("B_err_count", 32'(n_err - e0), 32'h0);

    // "*A12345<CR>" overflows the digit limit
    v0 = n_valid; e0 = n_err;
    send_str("*A1234");
    send_byte("5");
    check("ovf_err_on_5th", 32'(cmd_err), 32'h1);
    check("ovf_busy_flush", 32'(busy), 32'h1);
    repeat (2) @(negedge clk); #1;
    send_byte(8'h0D);
    check("ovf_busy_after_cr", 32'(busy), 32'h0);
    check("ovf_code_held", 32'(cmd_code), 32'h42);
    check("ovf_arg_held", 32'(cmd_arg), 32'hABCD);
    check("ovf_valid_count", 32'(n_valid - v0), 32'h0);
    check("ovf_err_count", 32'(n_err - e0), 32'h1);

    // "*A1" with framing error on '1', then "*C7<CR>"
    v0 = n_valid; e0 = n_err;
    send_str("*A");
    send_byte("1", 1'b1);
    check("fe_err", 32'(cmd_err), 32'h1);
    send_str("*C7");
    send_byte(8'h0D);
    check("C_code", 32'(cmd_code), 32'h43);
    check("C_arg", 32'(cmd_arg), 32'h0007);
    check("C_cnt", 32'(cmd_arg_cnt), 32'h1);
    check("fe_err_count", 32'(n_err - e0), 32'h1);
    check("fe_valid_count", 32'(n_valid - v0), 32'h1);

    // "*A1" then silence: error exactly on the TO-th silent cycle
    e0 = n_err; v0 = n_valid;
    send_str("*A");
    send_byte("1");
    repeat (TO - 1) @(negedge clk); #1;
    check("to_before_busy", 32'(busy), 32'h1);
    check("to_before_err", 32'(n_err - e0), 32'h0);
    @(negedge clk); #1;
    check("to_err_strobe", 32'(cmd_err), 32'h1);
    check("to_busy_cleared", 32'(busy), 32'h0);
    send_byte(8'h0D);
    repeat (3) @(negedge clk); #1;
    check("to_cr_no_strobe", 32'(n_valid - v0) + 32'(n_err - e0), 32'h1);

    // Reset mid-command discards the partial command
    v0 = n_valid; e0 = n_err;
    send_str("*A12");
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0; #1;
    check("rst_outputs", {cmd_valid, cmd_err, busy, cmd_code, cmd_arg, cmd_arg_cnt}, 32'h0);
    send_str("*D5");
    send_byte(8'h0D);
    check("D_valid", 32'(cmd_valid), 32'h1);
    check("D_code", 32'(cmd_code), 32'h44);
    check("D_arg", 32'(cmd_arg), 32'h0005);
    check("D_cnt", 32'(cmd_arg_cnt), 32'h1);
    check("rst_err_count", 32'(n_err - e0), 32'h0);

    // Byte arriving on the expiry cycle beats the timeout; LF aborts
    e0 = n_err;
    send_byte("*");
    repeat (TO - 2) @(negedge clk);
    send_byte("f");
    send_byte(8'h0A);
    check("lf_err", 32'(cmd_err), 32'h1);
    send_byte(8'h0D);
    repeat (3) @(negedge clk); #1;
    check("late_byte_err_count", 32'(n_err - e0), 32'h1);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
